// File: rtl/seq_window_checker.sv
`default_nettype none
// ============================================================================
// Module   : seq_window_checker
// Purpose  : Protocol checker for a/b request sequencing. After a rising edge
//            on i_start, a b request opens a window. The number of a requests
//            counted before the next b must lie in [MIN_A, MAX_A]. N_WIN
//            consecutive legal windows complete the check. Any violation
//            pulses o_fail, latches an error code and returns to idle.
// Optional : define SEQ_CHK_TIMEOUT_EN to add a watchdog. It fails with code 5
//            when TIMEOUT cycles pass without a b request.
// Ports    : clk          clock, rising edge
//            rst          asynchronous active-high reset
//            i_start      rising edge arms or restarts the checker
//            i_a, i_b     request strobes, sampled every cycle
//            o_busy       checker is armed (WAIT_OPEN or COUNT)
//            o_pass       one-cycle pulse per legal window
//            o_fail       one-cycle pulse on a violation
//            o_done       one-cycle pulse when all N_WIN windows passed
//            o_err_code   0 none, 1 orphan a, 2 a/b collision,
//                         3 count low, 4 count high, 5 timeout
//            o_win_cnt    windows passed since the last start edge
//            o_a_cnt      a requests counted in the current window
// Revision : 1.0 - initial release
// ============================================================================
module seq_window_checker #(
  parameter int unsigned MIN_A   = 1,
  parameter int unsigned MAX_A   = 1,
  parameter int unsigned N_WIN   = 1,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned WIN_W   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_a,
  input  logic             i_b,
  output logic             o_busy,
  output logic             o_pass,
  output logic             o_fail,
  output logic             o_done,
  output logic [2:0]       o_err_code,
  output logic [WIN_W-1:0] o_win_cnt,
  output logic [CNT_W-1:0] o_a_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_OPEN = 2'd1,
    ST_COUNT     = 2'd2
  } state_t;

  localparam logic [2:0] c_err_none    = 3'd0;
  localparam logic [2:0] c_err_orphan  = 3'd1;
  localparam logic [2:0] c_err_collide = 3'd2;
  localparam logic [2:0] c_err_low     = 3'd3;
  localparam logic [2:0] c_err_high    = 3'd4;

  // Sized copies of the limits so every compare is width-matched.
  localparam logic [CNT_W:0]   c_max_a   = MAX_A[CNT_W:0];
  localparam logic [CNT_W-1:0] c_min_a   = MIN_A[CNT_W-1:0];
  localparam logic [WIN_W-1:0] c_n_win   = N_WIN[WIN_W-1:0];
  localparam logic [WIN_W-1:0] c_win_one = {{(WIN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   c_cnt_one = {{CNT_W{1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_start_q;
  logic             r_busy;
  logic             r_pass;
  logic             r_fail;
  logic             r_done;
  logic [2:0]       r_err_code;
  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_a_cnt;

  state_t           w_state_nxt;
  logic             w_pass_nxt;
  logic             w_fail_nxt;
  logic             w_done_nxt;
  logic [2:0]       w_err_nxt;
  logic [WIN_W-1:0] w_win_nxt;
  logic [CNT_W-1:0] w_a_cnt_nxt;

  logic             w_start_edge;
  logic [CNT_W:0]   w_a_inc;
  logic [WIN_W-1:0] w_win_inc;

  assign w_start_edge = i_start & ~r_start_q;
  // One extra bit so a count of MAX_A+1 is still representable for the check.
  assign w_a_inc      = {1'b0, r_a_cnt} + c_cnt_one;
  assign w_win_inc    = r_win_cnt + c_win_one;

`ifdef SEQ_CHK_TIMEOUT_EN
  localparam logic [2:0]  c_err_tmo   = 3'd5;
  localparam logic [16:0] c_timeout   = TIMEOUT[16:0];
  localparam logic [16:0] c_tmr_one   = 17'd1;

  logic [15:0] r_timer;
  logic [15:0] w_timer_nxt;
  logic [16:0] w_timer_inc;
  logic        w_timeout;

  assign w_timer_inc = {1'b0, r_timer} + c_tmr_one;
  // The cycle that would bring the timer up to TIMEOUT is the expiring one,
  // unless a b arrives in that same cycle.
  assign w_timeout   = (r_state != ST_IDLE) && !i_b && (w_timer_inc >= c_timeout);

  always_comb begin
    w_timer_nxt = r_timer;
    if (w_start_edge || i_b) begin
      w_timer_nxt = 16'd0;
    end else if (r_state != ST_IDLE) begin
      w_timer_nxt = w_timer_inc[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= 16'd0;
    end else begin
      r_timer <= w_timer_nxt;
    end
  end
`else
  // TIMEOUT only feeds the optional watchdog; this empty block keeps the
  // parameter referenced in builds without it.
  if (TIMEOUT == 0) begin : g_no_timer
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_pass_nxt  = 1'b0;
    w_fail_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err_code;
    w_win_nxt   = r_win_cnt;
    w_a_cnt_nxt = r_a_cnt;

    if (w_start_edge) begin
      // A start edge overrides anything sampled with it, in every state.
      w_state_nxt = ST_WAIT_OPEN;
      w_err_nxt   = c_err_none;
      w_win_nxt   = '0;
      w_a_cnt_nxt = '0;
    end else begin
      case (r_state)
        ST_WAIT_OPEN: begin
          if (i_a && i_b) begin
            w_fail_nxt = 1'b1;
            w_err_nxt  = c_err_collide;
          end else if (i_a) begin
            w_fail_nxt = 1'b1;
            w_err_nxt  = c_err_orphan;
          end else if (i_b) begin
            w_state_nxt = ST_COUNT;
            w_a_cnt_nxt = '0;
          end
        end
        ST_COUNT: begin
          if (i_a && i_b) begin
            w_fail_nxt = 1'b1;
            w_err_nxt  = c_err_collide;
          end else if (i_a) begin
            // The overflowing count is kept so o_a_cnt shows what was seen.
            w_a_cnt_nxt = w_a_inc[CNT_W-1:0];
            if (w_a_inc > c_max_a) begin
              w_fail_nxt = 1'b1;
              w_err_nxt  = c_err_high;
            end
          end else if (i_b) begin
            if (r_a_cnt < c_min_a) begin
              w_fail_nxt = 1'b1;
              w_err_nxt  = c_err_low;
            end else begin
              // The closing b also opens the next window.
              w_pass_nxt  = 1'b1;
              w_win_nxt   = w_win_inc;
              w_a_cnt_nxt = '0;
              if (w_win_inc == c_n_win) begin
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
              end
            end
          end
        end
        default: begin
          // Idle: a and b are ignored until armed.
        end
      endcase

`ifdef SEQ_CHK_TIMEOUT_EN
      // Protocol violations report their own code before the watchdog.
      if (w_timeout && !w_fail_nxt && !w_pass_nxt) begin
        w_fail_nxt  = 1'b1;
        w_err_nxt   = c_err_tmo;
      end
`endif

      if (w_fail_nxt) begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_start_q  <= 1'b0;
      r_busy     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_done     <= 1'b0;
      r_err_code <= c_err_none;
      r_win_cnt  <= '0;
      r_a_cnt    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_start_q  <= i_start;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_pass     <= w_pass_nxt;
      r_fail     <= w_fail_nxt;
      r_done     <= w_done_nxt;
      r_err_code <= w_err_nxt;
      r_win_cnt  <= w_win_nxt;
      r_a_cnt    <= w_a_cnt_nxt;
    end
  end

  assign o_busy     = r_busy;
  assign o_pass     = r_pass;
  assign o_fail     = r_fail;
  assign o_done     = r_done;
  assign o_err_code = r_err_code;
  assign o_win_cnt  = r_win_cnt;
  assign o_a_cnt    = r_a_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_window_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_window_checker
// Purpose  : Scoreboard bench for seq_window_checker. Three instances:
//            d0 defaults, d1 MIN_A=2/MAX_A=3/N_WIN=2, d2 TIMEOUT=8.
//            Stimulus pushes the expected pass/fail response into a per
//            instance queue; a monitor pops and compares on every pass or
//            fail pulse. Build with SEQ_CHK_TIMEOUT_EN to cover the watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_window_checker;

  typedef struct packed {
    logic       pass;
    logic       fail;
    logic       done;
    logic [2:0] err;
    logic [3:0] win;
    logic [3:0] acnt;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       s0, a0, b0, s1, a1, b1, s2, a2, b2;
  logic       busy0, pass0, fail0, done0;
  logic       busy1, pass1, fail1, done1;
  logic       busy2, pass2, fail2, done2;
  logic [2:0] err0, err1, err2;
  logic [3:0] win0, win1, win2, ac0, ac1, ac2;

  seq_window_checker u_d0 (
    .clk(clk), .rst(rst), .i_start(s0), .i_a(a0), .i_b(b0),
    .o_busy(busy0), .o_pass(pass0), .o_fail(fail0), .o_done(done0),
    .o_err_code(err0), .o_win_cnt(win0), .o_a_cnt(ac0)
  );

  seq_window_checker #(.MIN_A(2), .MAX_A(3), .N_WIN(2)) u_d1 (
    .clk(clk), .rst(rst), .i_start(s1), .i_a(a1), .i_b(b1),
    .o_busy(busy1), .o_pass(pass1), .o_fail(fail1), .o_done(done1),
    .o_err_code(err1), .o_win_cnt(win1), .o_a_cnt(ac1)
  );

  seq_window_checker #(.TIMEOUT(8)) u_d2 (
    .clk(clk), .rst(rst), .i_start(s2), .i_a(a2), .i_b(b2),
    .o_busy(busy2), .o_pass(pass2), .o_fail(fail2), .o_done(done2),
    .o_err_code(err2), .o_win_cnt(win2), .o_a_cnt(ac2)
  );

  int    checks = 0;
  int    errors = 0;
  resp_t q0[$];
  resp_t q1[$];
  resp_t q2[$];

  function automatic resp_t mk(input logic p, input logic f, input logic d,
                               input int e, input int w, input int c);
    resp_t r;
    r.pass = p; r.fail = f; r.done = d;
    r.err  = e[2:0]; r.win = w[3:0]; r.acnt = c[3:0];
    return r;
  endfunction

  // Monitor: every pass/fail pulse must match the oldest expected response.
  task automatic mon_one(input string nm, input resp_t act, inout resp_t q[$]);
    resp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected response p=%b f=%b d=%b err=%0d win=%0d acnt=%0d, required none",
               nm, act.pass, act.fail, act.done, act.err, act.win, act.acnt);
    end else begin
      e = q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s response p=%b f=%b d=%b err=%0d win=%0d acnt=%0d, required p=%b f=%b d=%b err=%0d win=%0d acnt=%0d",
                 nm, act.pass, act.fail, act.done, act.err, act.win, act.acnt,
                 e.pass, e.fail, e.done, e.err, e.win, e.acnt);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pass0 || fail0) mon_one("d0", {pass0, fail0, done0, err0, win0, ac0}, q0);
      if (pass1 || fail1) mon_one("d1", {pass1, fail1, done1, err1, win1, ac1}, q1);
      if (pass2 || fail2) mon_one("d2", {pass2, fail2, done2, err2, win2, ac2}, q2);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", nm, act, exp);
    end
  endtask

  // One sampled cycle on instance d; outputs it causes are visible on return.
  task automatic cyc(input int d, input logic s, input logic a, input logic b);
    {s0, a0, b0, s1, a1, b1, s2, a2, b2} = '0;
    case (d)
      0: {s0, a0, b0} = {s, a, b};
      1: {s1, a1, b1} = {s, a, b};
      default: {s2, a2, b2} = {s, a, b};
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) cyc(d, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    {s0, a0, b0, s1, a1, b1, s2, a2, b2} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy0), 0);
    chk("rst_pulses", int'({pass0, fail0, done0}), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_cnts", int'({win0, ac0}), 0);
    rst = 1'b0;
    idle(0, 2);

    // Single legal window: b a b -> pass + done.
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 1); cyc(0, 0, 1, 0);
    q0.push_back(mk(1, 0, 1, 0, 1, 0));
    cyc(0, 0, 0, 1);
    chk("t1_busy", int'(busy0), 0);
    chk("t1_win", int'(win0), 1);
    idle(0, 1);

    // b b -> count low.
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 1);
    q0.push_back(mk(0, 1, 0, 3, 0, 0));
    cyc(0, 0, 0, 1);
    chk("t2_busy", int'(busy0), 0);
    idle(0, 1);

    // b a a -> count high on the second a; later a, b are ignored.
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 1); cyc(0, 0, 1, 0);
    q0.push_back(mk(0, 1, 0, 4, 0, 2));
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 1);
    chk("t3_err_hold", int'(err0), 4);
    chk("t3_acnt_frozen", int'(ac0), 2);
    idle(0, 1);

    // Collision before the window opens, then orphan a.
    cyc(0, 1, 0, 0);
    q0.push_back(mk(0, 1, 0, 2, 0, 0));
    cyc(0, 0, 1, 1);
    idle(0, 1);
    cyc(0, 1, 0, 0);
    q0.push_back(mk(0, 1, 0, 1, 0, 0));
    cyc(0, 0, 1, 0);
    idle(0, 1);

    // Restart mid-window clears counters without a response.
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 1); cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    chk("rs_acnt", int'(ac0), 0);
    chk("rs_busy", int'(busy0), 1);
    cyc(0, 0, 0, 1); cyc(0, 0, 1, 0);
    q0.push_back(mk(1, 0, 1, 0, 1, 0));
    cyc(0, 0, 0, 1);
    idle(0, 1);

    // Start edge wins over a collision sampled with it.
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 1);
    chk("prio_busy", int'(busy0), 1);
    chk("prio_err", int'(err0), 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 1, 0);
    q0.push_back(mk(1, 0, 1, 0, 1, 0));
    cyc(0, 0, 0, 1);
    idle(0, 1);

`ifndef SEQ_CHK_TIMEOUT_EN
    // Without the watchdog a long gap is harmless.
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 1);
    idle(0, 20);
    cyc(0, 0, 1, 0);
    q0.push_back(mk(1, 0, 1, 0, 1, 0));
    cyc(0, 0, 0, 1);
    idle(0, 1);
`endif

    // Two windows with MIN_A=2, MAX_A=3.
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 1); cyc(1, 0, 1, 0); cyc(1, 0, 1, 0);
    q1.push_back(mk(1, 0, 0, 0, 1, 0));
    cyc(1, 0, 0, 1);
    chk("d1_busy_mid", int'(busy1), 1);
    cyc(1, 0, 1, 0); cyc(1, 0, 1, 0); cyc(1, 0, 1, 0);
    q1.push_back(mk(1, 0, 1, 0, 2, 0));
    cyc(1, 0, 0, 1);
    chk("d1_busy_end", int'(busy1), 0);
    chk("d1_win", int'(win1), 2);
    idle(1, 1);

    // One a is below MIN_A=2.
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 1); cyc(1, 0, 1, 0);
    q1.push_back(mk(0, 1, 0, 3, 0, 1));
    cyc(1, 0, 0, 1);
    idle(1, 1);

    // Fourth a exceeds MAX_A=3.
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 1);
    cyc(1, 0, 1, 0); cyc(1, 0, 1, 0); cyc(1, 0, 1, 0);
    q1.push_back(mk(0, 1, 0, 4, 0, 4));
    cyc(1, 0, 1, 0);
    idle(1, 1);

`ifdef SEQ_CHK_TIMEOUT_EN
    // b then eight idle cycles -> timeout on the eighth.
    cyc(2, 1, 0, 0); cyc(2, 0, 0, 1);
    idle(2, 7);
    chk("tmo_busy_before", int'(busy2), 1);
    q2.push_back(mk(0, 1, 0, 5, 0, 0));
    idle(2, 1);
    chk("tmo_busy_after", int'(busy2), 0);
    idle(2, 1);

    // Restart mid-window: no fail, counters clear.
    cyc(2, 1, 0, 0); cyc(2, 0, 0, 1); cyc(2, 0, 1, 0);
    cyc(2, 1, 0, 0);
    chk("tmo_rs_acnt", int'(ac2), 0);
    cyc(2, 0, 0, 1); cyc(2, 0, 1, 0);
    q2.push_back(mk(1, 0, 1, 0, 1, 0));
    cyc(2, 0, 0, 1);
`endif

    idle(0, 3);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
